// File: rtl/memory_copy_engine.sv
// Word-granular copy/fill engine that masters the data-memory port.
// Overlapping copies pick a descending walk so source words are read before being overwritten.
module memory_copy_engine #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clock,
  input  logic          Rn,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW:0]   Len,
  input  logic [DW-1:0] FillData,
  output logic [AW-1:0] MemAddy,
  output logic          MemWriteEn,
  output logic [DW-1:0] MemWriteData,
  input  logic [DW-1:0] MemReadData,
  output logic          Busy,
  output logic          Done,
  output logic [AW:0]   Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  function automatic logic [AW-1:0] step_ptr(input logic [AW-1:0] ptr, input logic down);
    if (down) begin
      step_ptr = ptr - AW'(1);
    end else begin
      step_ptr = ptr + AW'(1);
    end
  endfunction

  state_t        state_r;
  logic [AW-1:0] src_ptr_r;
  logic [AW-1:0] dst_ptr_r;
  logic [AW:0]   remain_r;
  logic [DW-1:0] fill_r;
  logic          mode_r;
  logic          desc_r;

  logic [AW:0]   len_s;
  logic [AW:0]   src_end_s;
  logic          desc_s;
  logic [AW-1:0] src_first_s;
  logic [AW-1:0] dst_first_s;
  logic [AW-1:0] src_next_s;
  logic [AW-1:0] dst_next_s;

  // Operand decode for a Start request: clamp, overlap direction, first pointers.
  always_comb begin
    len_s       = Len;
    src_end_s   = {(AW+1){1'b0}};
    desc_s      = 1'b0;
    src_first_s = SrcAddr;
    dst_first_s = DstAddr;
    if (Len > MAX_LEN) begin
      len_s = MAX_LEN;
    end else begin
      len_s = Len;
    end
    // Unwrapped AW+1 bit sum: an overlap that spans the top of memory is not detected.
    src_end_s = {1'b0, SrcAddr} + len_s;
    if (!Mode && (DstAddr > SrcAddr) && ({1'b0, DstAddr} < src_end_s)) begin
      desc_s = 1'b1;
    end else begin
      desc_s = 1'b0;
    end
    if (desc_s) begin
      src_first_s = SrcAddr + len_s[AW-1:0] - AW'(1);
      dst_first_s = DstAddr + len_s[AW-1:0] - AW'(1);
    end else begin
      src_first_s = SrcAddr;
      dst_first_s = DstAddr;
    end
  end

  // Pointer stepping in the captured direction.
  always_comb begin
    src_next_s = step_ptr(src_ptr_r, desc_r);
    dst_next_s = step_ptr(dst_ptr_r, desc_r);
  end

  // Control FSM; memory port, Busy and Done are registered so they depend only on state.
  // MemWriteData doubles as the hold register for the word read in RD.
  always_ff @(posedge Clock or negedge Rn) begin
    if (!Rn) begin
      state_r      <= IDLE;
      src_ptr_r    <= {AW{1'b0}};
      dst_ptr_r    <= {AW{1'b0}};
      remain_r     <= {(AW+1){1'b0}};
      fill_r       <= {DW{1'b0}};
      mode_r       <= 1'b0;
      desc_r       <= 1'b0;
      Count        <= {(AW+1){1'b0}};
      MemAddy      <= {AW{1'b0}};
      MemWriteEn   <= 1'b0;
      MemWriteData <= {DW{1'b0}};
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            src_ptr_r <= src_first_s;
            dst_ptr_r <= dst_first_s;
            remain_r  <= len_s;
            fill_r    <= FillData;
            mode_r    <= Mode;
            desc_r    <= desc_s;
            Count     <= {(AW+1){1'b0}};
            Busy      <= 1'b1;
            if (len_s == {(AW+1){1'b0}}) begin
              state_r      <= FIN;
              Done         <= 1'b1;
              MemAddy      <= {AW{1'b0}};
              MemWriteEn   <= 1'b0;
              MemWriteData <= {DW{1'b0}};
            end else if (Mode) begin
              state_r      <= WR;
              Done         <= 1'b0;
              MemAddy      <= dst_first_s;
              MemWriteEn   <= 1'b1;
              MemWriteData <= FillData;
            end else begin
              state_r      <= RD;
              Done         <= 1'b0;
              MemAddy      <= src_first_s;
              MemWriteEn   <= 1'b0;
              MemWriteData <= {DW{1'b0}};
            end
          end else begin
            state_r      <= IDLE;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            MemAddy      <= {AW{1'b0}};
            MemWriteEn   <= 1'b0;
            MemWriteData <= {DW{1'b0}};
          end
        end

        RD: begin
          state_r      <= WR;
          src_ptr_r    <= src_next_s;
          MemAddy      <= dst_ptr_r;
          MemWriteEn   <= 1'b1;
          MemWriteData <= MemReadData;
        end

        WR: begin
          dst_ptr_r <= dst_next_s;
          Count     <= Count + (AW+1)'(1);
          remain_r  <= remain_r - (AW+1)'(1);
          if (remain_r == (AW+1)'(1)) begin
            state_r      <= FIN;
            Done         <= 1'b1;
            MemAddy      <= {AW{1'b0}};
            MemWriteEn   <= 1'b0;
            MemWriteData <= {DW{1'b0}};
          end else if (mode_r) begin
            state_r      <= WR;
            MemAddy      <= dst_next_s;
            MemWriteEn   <= 1'b1;
            MemWriteData <= fill_r;
          end else begin
            state_r      <= RD;
            MemAddy      <= src_ptr_r;
            MemWriteEn   <= 1'b0;
            MemWriteData <= {DW{1'b0}};
          end
        end

        FIN: begin
          state_r      <= IDLE;
          Busy         <= 1'b0;
          Done         <= 1'b0;
          MemAddy      <= {AW{1'b0}};
          MemWriteEn   <= 1'b0;
          MemWriteData <= {DW{1'b0}};
        end

        default: begin
          state_r      <= IDLE;
          Busy         <= 1'b0;
          Done         <= 1'b0;
          MemAddy      <= {AW{1'b0}};
          MemWriteEn   <= 1'b0;
          MemWriteData <= {DW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/memory_copy_engine.md
# memory_copy_engine

Word-granular copy/fill engine that drives the data-memory port as its initiator. It owns the memory's write-enable, address, and write-data inputs and consumes its combinational read-data output. Software starts a copy (read source word, write destination word) or a fill (write a constant) over up to 32 words. Overlapping copies are handled by choosing the transfer direction. It sits beside the datapath and is muxed onto the memory port while its Busy output is high.

## Interface
- AW, 5, word-address width; memory depth is 2^AW.
- DW, 32, data word width.
- Clock  in  1  single clock; all state updates on the rising edge.
- Rn  in  1  reset, asynchronous, active-low; clears all state immediately when 0.
- Start  in  1  request pulse; sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; captured with Start.
- SrcAddr  in  AW  first source word address (copy only); captured with Start.
- DstAddr  in  AW  first destination word address; captured with Start.
- Len  in  AW+1  word count; captured with Start; values above 2^AW are clamped to 2^AW.
- FillData  in  DW  fill constant; captured with Start.
- MemAddy  out  AW  address to the memory.
- MemWriteEn  out  1  memory write enable; the write lands on the next rising Clock.
- MemWriteData  out  DW  memory write data.
- MemReadData  in  DW  memory read data; combinational from MemAddy, so it is valid in the same cycle.
- Busy  out  1  high in RD, WR and FIN.
- Done  out  1  single-cycle pulse in FIN.
- Count  out  AW+1  words written so far in the current or last operation.

## Operation
- FSM states: IDLE, RD, WR, FIN.
- IDLE, Start=1, captured length 0 -> FIN.
- IDLE, Start=1, copy -> RD.
- IDLE, Start=1, fill -> WR.
- RD: MemAddy=src_ptr and MemWriteEn=0. Capture MemReadData into the hold register, advance src_ptr, then go to WR.
- WR: MemAddy=dst_ptr, MemWriteEn=1, MemWriteData = hold (copy) or the FillData latch (fill). Advance dst_ptr, increment Count, decrement remaining.
  - If remaining was 1 -> FIN.
  - Otherwise -> RD (copy) or WR (fill).
- FIN: Done=1, then -> IDLE.
- Direction:
  - Descending when Mode=0 and Dst > Src and Dst < Src+Len. This comparison is unsigned, done in AW+1 bits with no wrap.
  - Otherwise ascending.
  - Descending pointers start at Src+Len-1 and Dst+Len-1 (mod 2^AW) and decrement.
- All pointers wrap mod 2^AW (for example, 31+1 -> 0 and 0-1 -> 31).
- Count clears to 0 on an accepted Start and holds its value in IDLE after completion.
- Start while Busy=1 is ignored; the captured operands do not change.
- Src == Dst copy: performs L read/write pairs and rewrites identical data.
- In IDLE and FIN: MemWriteEn=0, MemAddy=0, MemWriteData=0.

## Timing
- Reset (Rn=0), all asynchronous:
  - state = IDLE.
  - Busy = 0, Done = 0, Count = 0.
  - MemWriteEn = 0, MemAddy = 0, MemWriteData = 0.
  - Pointers and hold register = 0.
- Rn asserted mid-operation: MemWriteEn drops immediately. Words already written stay written, and no Done is produced.
- Start is accepted at rising edge k; Busy is high from cycle k+1.
- Copy of L words: RD/WR alternate over cycles k+1 .. k+2L, and Done is high in cycle k+2L+1.
- Fill of L words: WR over cycles k+1 .. k+L, and Done is high in cycle k+L+1.
- Len=0: Done is high in cycle k+1 and no write occurs.
- A new Start is accepted in the first IDLE cycle after FIN, which gives back-to-back operations one idle cycle apart.
- MemWriteEn, MemAddy and MemWriteData are decoded only from registered state and pointers, never from same-cycle inputs.

## Test plan
- Reset, then fill Dst=4, Len=3, FillData=0xA5A5A5A5 -> writes at cycles 1-3 to addresses 4, 5, 6; Done in cycle 4; Count=3; memory[4..6]=0xA5A5A5A5.
- Preload memory[0..3]=1,2,3,4; copy Src=0, Dst=2, Len=4 (overlap, descending) -> write order 5, 4, 3, 2; memory[2..5]=1,2,3,4; Done in cycle 9.
- Copy Src=10, Dst=8, Len=3 (overlap, ascending) -> memory[8..10] equals the old memory[10..12]; write order 8, 9, 10.
- Fill Dst=30, Len=4 -> writes to 30, 31, 0, 1 (wrap); Len=40 -> clamped, 32 writes, Count=32.
- Len=0 -> Done in cycle 1 with no MemWriteEn; Start pulsed during a copy -> ignored and the operands are unchanged.
- Drop Rn for one cycle during the WR of word 2 of 5 -> MemWriteEn is 0 within the same cycle; state returns to IDLE, Busy=0, Count=0, no Done, and memory holds exactly one new word.
